cam_table_loader: RTL
=====================

# cam_table_loader

Generates the full-adder lookup table (8 × 2-bit) and the carry-merge sum table (128 × 5-bit) that program the 4-bit TCAM adder. The tables are built one entry per cycle into registered arrays, which connect directly to the adder's `data_add`/`data` inputs. The block then issues a single-cycle `write_en` commit pulse. A patch port allows individual sum entries to be overwritten and re-committed, for fault-injection and table experiments.

## Interface
- Parameters: none. Depths and widths are fixed constants in `cam_pkg`.
- `clk` in 1: single clock; all state changes on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin table generation; accepted only in IDLE or DONE.
- `commit` in 1: re-issue the commit pulse with the current tables; accepted only in DONE.
- `tbl_wr_en` in 1: patch-write strobe for the sum table; accepted only in IDLE or DONE.
- `tbl_wr_addr` in 7: patch index.
- `tbl_wr_data` in 5: patch value.
- `data_add` out 2 × [7:0]: full-adder table.
- `data` out 5 × [127:0]: sum table.
- `write_en` out 1: one-cycle commit pulse to the adder.
- `busy` out 1: high in GEN_ADD, GEN_SUM and COMMIT.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, GEN_ADD, GEN_SUM, COMMIT, DONE. An index counter `idx` (7 bits) is cleared on every state entry.
- IDLE
  - `start` → GEN_ADD.
- GEN_ADD (8 cycles)
  - Each cycle writes `data_add[idx] = {maj(idx[2],idx[1],idx[0]), idx[2]^idx[1]^idx[0]}`.
  - Bit 0 is the sum bit; bit 1 is the carry bit.
  - After `idx==7` → GEN_SUM.
- GEN_SUM (128 cycles)
  - Each cycle writes `data[p]`, with `p = {s3,s2,s1,c3,c2,c1,c0}`.
  - `data[p] = (p[0]+p[4]) + 2·(p[1]+p[5]) + 4·(p[2]+p[6]) + 8·p[3]`.
  - Computed in 6 bits, then truncated to 5. The maximum value is 22, so truncation never loses a bit.
  - After `idx==127` → COMMIT.
- COMMIT (1 cycle)
  - `write_en=1`, then → DONE.
- DONE
  - `start` → GEN_ADD. All entries are regenerated, which erases any patches.
  - Otherwise, `commit` → COMMIT.
  - `start` and `commit` on the same cycle: `start` wins.
- Patch
  - `tbl_wr_en` in IDLE or DONE writes `data[tbl_wr_addr] <= tbl_wr_data` on that edge.
  - The patch is ignored while `busy`.
  - Patch together with `commit` in DONE: the patch lands on the same edge, so the following commit pulse sees the patched value.
- `start` or `commit` while `busy`: ignored, with no queuing.
- `commit` in IDLE: ignored, because the tables are not yet valid.

## Timing
- Reset values:
  - all `data`/`data_add` entries = 0
  - `write_en=0`, `busy=0`, `done=0`
  - state IDLE, `idx=0`
- All outputs are registered, with no combinational input-to-output path.
- `start` sampled at edge E0:
  - `busy` goes high after E0.
  - `data_add` entries are written at E1..E8.
  - `data` entries are written at E9..E136.
  - `write_en` is high between E136 and E137; the adder samples it at E137.
  - After E137: `busy=0`, `done=1`.
- Table outputs are stable for the whole `write_en` cycle.
- `commit` sampled in DONE at edge F0: `write_en` is high between F0 and F1, and `done` is low for that cycle only.
- `write_en` is never high for two consecutive cycles.
- Reset asserted mid-generation (asynchronous): the state machine and tables clear immediately. No `write_en` is emitted for the aborted run.

## Structure
- `cam_pkg` holds:
  - constants `ADD_DEPTH=8`, `SUM_DEPTH=128`, `ADD_W=2`, `SUM_W=5`, `IDX_W=7`
  - typedef `loader_state_e`
  - the array typedefs for both tables
  - functions `fa_entry(idx)` and `sum_entry(p)`
- The adder and this block both import `cam_pkg` so that widths cannot drift.
- One sub-module is natural: `cam_entry_gen`, a combinational block that wraps both functions for a given `idx`. It is shared with the bench's scoreboard model.

## Test plan
- Reset, then `start` → `write_en` is seen at exactly the 137th edge after the start edge. After the pulse, `data_add[3]=2'b10`, `data_add[7]=2'b11`, `data_add[0]=2'b00`, `data[0]=0`, `data[127]=22`, `data[7'h11]=2`.
- Full run feeding the adder, then sweep all 4096 {a,b,c} → adder `sum` == `actual_sum` for every vector.
- In DONE, patch `data[127]=0` and `commit` on the same cycle → one `write_en` pulse on the next cycle; `data[127]=0`; a=b=c=4'hF returns a wrong sum, proving the patch reached the adder.
- `start` pulsed at cycle 50 of GEN_SUM, plus `tbl_wr_en` while busy → no restart, no patch applied, a single `write_en` at edge 137, table matches the model.
- `rst_n` low at cycle 70 → outputs zero immediately; `write_en` never asserts; a new `start` completes normally.
- `commit` in IDLE after reset → no `write_en`, state remains IDLE.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared widths, table types and entry functions for the TCAM adder and its table loader.
package cam_pkg;

  localparam int ADD_DEPTH = 8;
  localparam int SUM_DEPTH = 128;
  localparam int ADD_W     = 2;
  localparam int SUM_W     = 5;
  localparam int IDX_W     = 7;

  typedef logic [2:0] loader_state_e;

  localparam loader_state_e S_IDLE    = 3'd0;
  localparam loader_state_e S_GEN_ADD = 3'd1;
  localparam loader_state_e S_GEN_SUM = 3'd2;
  localparam loader_state_e S_COMMIT  = 3'd3;
  localparam loader_state_e S_DONE    = 3'd4;

  typedef logic [ADD_DEPTH-1:0][ADD_W-1:0] add_tbl_t;
  typedef logic [SUM_DEPTH-1:0][SUM_W-1:0] sum_tbl_t;

  // Bit 0 is the sum bit, bit 1 the carry (majority) bit.
  function automatic logic [ADD_W-1:0] fa_entry(input logic [2:0] i);
    return {(i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]), i[2] ^ i[1] ^ i[0]};
  endfunction

  // p = {s3,s2,s1,c3,c2,c1,c0}; the result never exceeds 22, so 5 bits suffice.
  function automatic logic [SUM_W-1:0] sum_entry(input logic [IDX_W-1:0] p);
    logic [5:0] s;
    s = ({5'd0, p[0]} + {5'd0, p[4]})
      + (({5'd0, p[1]} + {5'd0, p[5]}) << 1)
      + (({5'd0, p[2]} + {5'd0, p[6]}) << 2)
      + ({5'd0, p[3]} << 3);
    return SUM_W'(s);
  endfunction

endpackage

// File: rtl/cam_table_loader_if.sv
// Control, patch and table-output bundle between the loader and its host/adder.
interface cam_table_loader_if;
  import cam_pkg::*;

  logic                  start;
  logic                  commit;
  logic                  tbl_wr_en;
  logic [IDX_W-1:0]      tbl_wr_addr;
  logic [SUM_W-1:0]      tbl_wr_data;
  add_tbl_t              data_add;
  sum_tbl_t              data;
  logic                  write_en;
  logic                  busy;
  logic                  done;

  modport master (
    output start, commit, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  data_add, data, write_en, busy, done
  );

  modport slave (
    input  start, commit, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output data_add, data, write_en, busy, done
  );

endinterface

// File: rtl/cam_entry_gen.sv
// Combinational generator of the full-adder and sum table entries for one index.
module cam_entry_gen
  import cam_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [ADD_W-1:0] fa_val,
  output logic [SUM_W-1:0] sum_val
);

  assign fa_val  = fa_entry(idx[2:0]);
  assign sum_val = sum_entry(idx);

endmodule

// File: rtl/cam_table_loader.sv
// Builds the TCAM adder lookup tables one entry per cycle, then pulses write_en to commit them.
module cam_table_loader
  import cam_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  cam_table_loader_if.slave bus
);

  loader_state_e    state, state_next;
  logic [IDX_W-1:0] idx;
  logic [ADD_W-1:0] fa_val;
  logic [SUM_W-1:0] sum_val;
  add_tbl_t         add_tbl;
  sum_tbl_t         sum_tbl;
  logic             write_en_q, busy_q, done_q;
  logic             patch_ok;

  cam_entry_gen u_gen (
    .idx     (idx),
    .fa_val  (fa_val),
    .sum_val (sum_val)
  );

  // In DONE, start takes priority over commit.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (bus.start) state_next = S_GEN_ADD;
      S_GEN_ADD: if (idx == IDX_W'(ADD_DEPTH - 1)) state_next = S_GEN_SUM;
      S_GEN_SUM: if (idx == IDX_W'(SUM_DEPTH - 1)) state_next = S_COMMIT;
      S_COMMIT:  state_next = S_DONE;
      S_DONE: begin
        if (bus.start)       state_next = S_GEN_ADD;
        else if (bus.commit) state_next = S_COMMIT;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  assign patch_ok = bus.tbl_wr_en && (state == S_IDLE || state == S_DONE);

  // Status flags are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      write_en_q <= (state_next == S_COMMIT);
      busy_q     <= (state_next == S_GEN_ADD) || (state_next == S_GEN_SUM) ||
                    (state_next == S_COMMIT);
      done_q     <= (state_next == S_DONE);
      if (state_next != state || (state != S_GEN_ADD && state != S_GEN_SUM))
        idx <= '0;
      else
        idx <= idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_tbl <= '0;
      sum_tbl <= '0;
    end else if (state == S_GEN_ADD) begin
      add_tbl[idx[2:0]] <= fa_val;
    end else if (state == S_GEN_SUM) begin
      sum_tbl[idx] <= sum_val;
    end else if (patch_ok) begin
      sum_tbl[bus.tbl_wr_addr] <= bus.tbl_wr_data;
    end
  end

  assign bus.data_add = add_tbl;
  assign bus.data     = sum_tbl;
  assign bus.write_en = write_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
